// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory controller.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the pipeline and the data memory.
interface data_mem_ctrl_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] DataAddress;
    logic              ReadMem;
    logic              WriteMem;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              RdValid;
    logic              Busy;

    modport master (
        output DataAddress,
        output ReadMem,
        output WriteMem,
        output DataIn,
        input  DataOut,
        input  RdValid,
        input  Busy
    );

    modport slave (
        input  DataAddress,
        input  ReadMem,
        input  WriteMem,
        input  DataIn,
        output DataOut,
        output RdValid,
        output Busy
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clear sweep after reset, single-cycle stores,
// two-cycle registered loads.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    data_mem_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rdvalid_q, rdvalid_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdvalid_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = bus.DataAddress;
        mem_wdata = bus.DataIn;

        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                // A store wins over a simultaneous load; the load is dropped.
                if (bus.WriteMem) begin
                    mem_we = 1'b1;
                end else if (bus.ReadMem) begin
                    addr_d  = bus.DataAddress;
                    state_d = READ;
                end
            end
            READ: begin
                dout_d    = mem_rdata;
                rdvalid_d = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.RdValid = rdvalid_q;
    assign bus.Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed cases plus random traffic.
module tb_data_mem_ctrl;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [256];
    exp_t       q [$];
    int         bz_start = 0;
    int         bz_until = 0;
    int         rst_cyc  = 0;
    bit         armed    = 1'b0;
    logic [7:0] exp_dout = 8'h00;

    data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_ctrl #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (256)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a load result.
    always @(negedge clk) begin
        if (armed && cyc > rst_cyc) begin
            exp_t e;
            if (cyc == rst_cyc + 1) exp_dout = 8'h00;
            chk("busy", int'(bus.Busy),
                int'(cyc > bz_start && cyc <= bz_until));
            if (bus.RdValid) begin
                if (q.size() == 0) begin
                    chk("rdvalid_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", int'(bus.DataOut), int'(e.data));
                    chk("rd_cycle", cyc, e.cyc);
                    exp_dout = e.data;
                end
            end else begin
                chk("dout_hold", int'(bus.DataOut), int'(exp_dout));
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    chk("rdvalid_missing", 0, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
        bus.ReadMem     = rd;
        bus.WriteMem    = wr;
        bus.DataAddress = a;
        bus.DataIn      = d;
        if (cyc > bz_until) begin
            if (wr) begin
                ref_mem[a] = d;
            end else if (rd) begin
                q.push_back('{ref_mem[a], cyc + 2});
                bz_start = cyc;
                bz_until = cyc + 2;
            end
        end
        tick();
        bus.ReadMem  = 1'b0;
        bus.WriteMem = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        rst_cyc = cyc;
        armed   = 1'b1;
        while (q.size() > 0 && q[$].cyc > rst_cyc) void'(q.pop_back());
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        bz_start = rst_cyc;
        bz_until = rst_cyc + 256;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && cyc <= bz_until; i++) tick();
    endtask

    initial begin
        bus.ReadMem     = 1'b0;
        bus.WriteMem    = 1'b0;
        bus.DataAddress = 8'h00;
        bus.DataIn      = 8'h00;
        tick();

        do_reset();
        wait_idle();
        issue(1, 0, 8'h00, 8'h00); wait_idle();
        issue(1, 0, 8'h7F, 8'h00); wait_idle();
        issue(1, 0, 8'hFF, 8'h00); wait_idle();

        issue(0, 1, 8'h10, 8'hA5);
        issue(1, 0, 8'h10, 8'h00);
        wait_idle();

        issue(1, 1, 8'h20, 8'h3C);
        tick(); tick();
        issue(1, 0, 8'h20, 8'h00); wait_idle();

        issue(1, 0, 8'h50, 8'h00);
        issue(0, 1, 8'h40, 8'h11);
        wait_idle();
        issue(1, 0, 8'h40, 8'h00); wait_idle();

        issue(0, 1, 8'hFF, 8'h5A);
        issue(1, 0, 8'hFF, 8'h00);
        do_reset();
        wait_idle();
        issue(1, 0, 8'hFF, 8'h00); wait_idle();

        issue(0, 1, 8'h00, 8'h01);
        issue(0, 1, 8'hFF, 8'hFE);
        issue(1, 0, 8'hFF, 8'h00); wait_idle();
        issue(1, 0, 8'h00, 8'h00); wait_idle();

        // Reset part-way through the sweep restarts it from address 0.
        do_reset();
        repeat (100) tick();
        do_reset();
        wait_idle();

        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [7:0]  a;
            logic [7:0]  d;
            r = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) a = {6'h3F, a[1:0]};
            d = 8'($urandom_range(0, 255));
            if (i == 250) begin
                do_reset();
            end else if (r <= 3) begin
                issue(1, 0, a, d);
            end else if (r <= 6) begin
                issue(0, 1, a, d);
            end else if (r == 7) begin
                issue(1, 1, a, d);
            end else begin
                tick();
            end
        end

        wait_idle();
        repeat (4) tick();
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have parameter DEPTH, default 256 (2**ADDR_W), number of words.
REQ-004 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 DataAddress  input  ADDR_W  address from the address-select mux.
REQ-007 ReadMem  input  1  load request, sampled only when Busy=0.
REQ-008 WriteMem  input  1  store request, sampled only when Busy=0.
REQ-009 DataIn  input  DATA_W  store data.
REQ-010 DataOut  output  DATA_W  load result, registered; holds its value between loads.
REQ-011 RdValid  output  1  one-cycle pulse, DataOut newly valid.
REQ-012 Busy  output  1  high in any state other than IDLE; upstream holds the request while it is high.

Function
REQ-013 SHALL implement FSM states CLEAR, IDLE, READ, RESP; Busy=1 in CLEAR, READ and RESP.
REQ-014 CLEAR: writes 0 to address ClrPtr each cycle, ClrPtr 0..DEPTH-1; after address DEPTH-1 is written, goes to IDLE (DEPTH cycles total); ClrPtr does not wrap.
REQ-015 IDLE, WriteMem=1: DataIn written to DataAddress at that edge; stays IDLE; no Busy cycle.
REQ-016 IDLE, ReadMem=1, WriteMem=0: DataAddress latched at edge T; state READ at T+1, RESP at T+2.
REQ-017 RESP: DataOut = mem[latched addr] and RdValid=1 for exactly that cycle; next state IDLE.
REQ-018 Load latency: request cycle T, data valid cycle T+2; Busy high in cycles T+1 and T+2.
REQ-019 IDLE, ReadMem=1 and WriteMem=1: write performed, read dropped, no RdValid.
REQ-020 ReadMem/WriteMem while Busy=1 SHALL be ignored; memory contents unchanged.
REQ-021 Store to address A at cycle T followed by load of A at T+1 SHALL return the stored value (no stale read).
REQ-022 Address range is the full ADDR_W space; no out-of-range condition exists.
REQ-023 DataOut SHALL change only in the RESP cycle or on reset.

Reset
REQ-024 Reset=1 at an edge: state CLEAR, ClrPtr=0, DataOut=0, RdValid=0, Busy=1 in the following cycle.
REQ-025 Reset mid-READ/RESP aborts the load (no RdValid) and restarts the full CLEAR sweep.
REQ-026 Reset mid-CLEAR restarts the sweep at address 0.
REQ-027 Memory contents SHALL be all-zero when the FSM first enters IDLE after reset.

Structure
REQ-028 Shared package dmem_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W/DEPTH defaults.
REQ-029 Storage SHALL be a sub-module dmem_array: one synchronous write port and one combinational read port; data_mem_ctrl muxes the write port between the CLEAR sweep and stores.
REQ-030 DataOut, RdValid and the latched address SHALL be flops in data_mem_ctrl; Busy is decoded from state only.

Verification
REQ-031 Reset pulse, idle inputs -> Busy=1 for 256 cycles then 0; load of 0x00, 0x7F, 0xFF each returns 0x00.
REQ-032 Store 0xA5 to 0x10, next cycle load 0x10 -> RdValid two cycles after the load request, DataOut=0xA5, Busy high for 2 cycles.
REQ-033 Simultaneous ReadMem=WriteMem=1, addr 0x20, DataIn 0x3C -> no RdValid, Busy stays 0; later load of 0x20 returns 0x3C.
REQ-034 Store 0x11 to 0x40 issued during the READ cycle of another load -> ignored; load of 0x40 returns 0x00.
REQ-035 Reset asserted in READ after store 0x5A to 0xFF -> no RdValid, DataOut=0, 256-cycle sweep; load of 0xFF returns 0x00.
REQ-036 Stores 0x01 to 0x00 and 0xFE to 0xFF, then loads of 0xFF and 0x00 -> 0xFE and 0x01 (boundary addresses).
